// File: rtl/proc_ctrl.sv
// Multi-cycle controller for a 4-register accumulator datapath.
// Decodes mv/mvi/add/sub from a latched instruction register into bus and load enables.
module proc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] instr,
  output logic [3:0] r_en,
  output logic [3:0] r_out,
  output logic       a_en,
  output logic       g_en,
  output logic       g_out,
  output logic       din_out,
  output logic       addsub,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t     state_q, state_d;
  logic [5:0] ir_q, ir_d;
  logic [1:0] op;
  logic [3:0] rx_oh, ry_oh;

  assign op    = ir_q[5:4];
  assign rx_oh = 4'b0001 << ir_q[3:2];
  assign ry_oh = 4'b0001 << ir_q[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs depend only on state_q/ir_q; run/instr only steer the IDLE transition.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    r_en    = '0;
    r_out   = '0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    addsub  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (run) begin
          ir_d    = instr;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          2'b00: begin
            r_out   = ry_oh;
            r_en    = rx_oh;
            done    = 1'b1;
            state_d = IDLE;
          end
          2'b01: begin
            din_out = 1'b1;
            r_en    = rx_oh;
            done    = 1'b1;
            state_d = IDLE;
          end
          default: begin
            r_out   = rx_oh;
            a_en    = 1'b1;
            state_d = T2;
          end
        endcase
      end
      T2: begin
        r_out   = ry_oh;
        g_en    = 1'b1;
        addsub  = op[0];
        state_d = T3;
      end
      T3: begin
        g_out   = 1'b1;
        r_en    = rx_oh;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
